program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface

Parameters:
- REQ-001: The block SHALL have parameter WIDTH, default 32, setting the bit width of pc_in and pc_out.
- REQ-002: The block SHALL have parameter RESET_VALUE, default 32'h0000_0000 (WIDTH bits), giving the value loaded into pc_out on reset.

Ports:
- REQ-003: The block SHALL have `clock`, input, 1 bit: the single clock; all state updates occur on its rising edge.
- REQ-004: The block SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
- REQ-005: The block SHALL have `pc_in`, input, WIDTH bits: next program-counter value from the fetch/branch logic.
- REQ-006: The block SHALL have `pc_out`, output, WIDTH bits: current program-counter value.
- REQ-007: The block SHALL have exactly one clock and one reset, and no other ports.

Function
- REQ-008: pc_out SHALL be driven directly from a single WIDTH-bit register, with no combinational path from pc_in or reset to pc_out.
- REQ-009: On each rising clock edge with reset=0, the register SHALL load pc_in unmodified: no increment, alignment, masking or sign change.
- REQ-010: Load latency SHALL be exactly one clock edge; a pc_in value present before edge N SHALL appear on pc_out immediately after edge N.
- REQ-011: pc_in changes between edges SHALL have no effect on pc_out until the next rising edge.
- REQ-012: pc_out SHALL hold its value between rising edges.
- REQ-013: Every bit pattern of pc_in SHALL be accepted and stored as-is, including all-zeros, all-ones and odd values such as 1 and 3.
- REQ-014: The block SHALL NOT wrap or saturate any value, because it performs no arithmetic.
- REQ-015: The block SHALL have no enable or stall input; it loads on every non-reset edge.
- REQ-016: Behaviour SHALL be identical for any WIDTH >= 1, with RESET_VALUE truncated or zero-extended to WIDTH.

Reset
- REQ-017: When reset=1 at a rising edge, pc_out SHALL become RESET_VALUE (0 by default) after that edge, regardless of pc_in.
- REQ-018: Reset SHALL be sampled only on rising edges; an assertion or deassertion between edges SHALL NOT change pc_out until the next edge.
- REQ-019: While reset stays high, pc_out SHALL remain RESET_VALUE on every edge.
- REQ-020: Reset SHALL take priority over pc_in whenever both are active at the same edge.
- REQ-021: On the first edge with reset=0 after reset, pc_out SHALL load pc_in.
- REQ-022: Reset asserted mid-sequence SHALL override the pending pc_in load at that edge.
- REQ-023: Before the first reset edge, pc_out is unspecified (X permitted in simulation).

Verification
- REQ-024: Reset hold: reset=1, pc_in=0 for 100 ns at a 4 ns clock period -> pc_out=0 after the first edge and stays 0 throughout.
- REQ-025: Reset priority: reset=1, pc_in=32'hDEAD_BEEF -> pc_out=0 at every edge.
- REQ-026: Sequential load: reset=0, then pc_in=1, 2, 3, each held 10 ns -> pc_out follows 1, 2, 3, each updating only at the first rising edge after the pc_in change.
- REQ-027: Mid-cycle change: pc_in changes from 5 to 7 while clock is high -> pc_out stays 5 until the next rising edge, then becomes 7.
- REQ-028: Extremes: pc_in=32'hFFFF_FFFF, then 32'h0000_0000 -> pc_out=32'hFFFF_FFFF, then 0, with no wrap.
- REQ-029: Reset mid-run: pc_out=3, reset pulsed high for one edge with pc_in=9 -> pc_out=0; on the next edge with reset=0 -> pc_out=9.

Source files
------------

// File: rtl/program_counter.sv
// Program counter register: holds the current fetch address and loads the
// next address from the fetch/branch logic on every rising clock edge.
module program_counter #(
    parameter int unsigned            WIDTH       = 32,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // No arithmetic: the next PC is taken verbatim from the fetch/branch logic.
    always_comb begin
        pc_d = pc_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver queues the value expected
// after each rising edge, and an independent monitor pops and compares.
module tb_program_counter;

    logic        clock;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [7:0]  pc_in8;
    logic [7:0]  pc_out8;

    typedef struct {
        logic [31:0] e32;
        logic [7:0]  e8;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    program_counter u_dut (
        .clock  (clock),
        .reset  (reset),
        .pc_in  (pc_in),
        .pc_out (pc_out)
    );

    program_counter #(
        .WIDTH       (8),
        .RESET_VALUE (8'h5A)
    ) u_dut8 (
        .clock  (clock),
        .reset  (reset),
        .pc_in  (pc_in8),
        .pc_out (pc_out8)
    );

    assign pc_in8 = pc_in[7:0];

    initial begin
        clock = 1'b0;
        forever #2 clock = ~clock;
    end

    // Monitor: edge-result check just after each rising edge, hold check
    // just after each falling edge against the last edge result.
    initial begin
        exp_t cur;
        exp_t last;
        bit   have_last;
        have_last = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                n_cmp++;
                if (pc_out !== cur.e32) begin
                    n_bad++;
                    $display("FAIL edge32 t=%0t got=%h want=%h", $time, pc_out, cur.e32);
                end
                n_cmp++;
                if (pc_out8 !== cur.e8) begin
                    n_bad++;
                    $display("FAIL edge8 t=%0t got=%h want=%h", $time, pc_out8, cur.e8);
                end
                last      = cur;
                have_last = 1'b1;
            end
            @(negedge clock);
            #1;
            if (have_last) begin
                n_cmp++;
                if (pc_out !== last.e32 || pc_out8 !== last.e8) begin
                    n_bad++;
                    $display("FAIL hold t=%0t got=%h/%h want=%h/%h", $time,
                             pc_out, pc_out8, last.e32, last.e8);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] e32, input logic [7:0] e8);
        exp_t e;
        e.e32 = e32;
        e.e8  = e8;
        exp_q.push_back(e);
    endtask

    // Drive inputs for the next rising edge and queue its expected result.
    task automatic cycle(input logic r, input logic [31:0] in,
                         input logic [31:0] e32, input logic [7:0] e8);
        reset = r;
        pc_in = in;
        push_exp(e32, e8);
        @(negedge clock);
    endtask

    // Drive for one edge, then change inputs while clock is high; the new
    // inputs are held through the following edge.
    task automatic mid(input logic r0, input logic [31:0] in0,
                       input logic [31:0] e0, input logic [7:0] e0_8,
                       input logic r1, input logic [31:0] in1,
                       input logic [31:0] e1, input logic [7:0] e1_8);
        reset = r0;
        pc_in = in0;
        push_exp(e0, e0_8);
        @(posedge clock);
        #1;
        reset = r1;
        pc_in = in1;
        push_exp(e1, e1_8);
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Reset hold: 100 ns at a 4 ns period
        for (int i = 0; i < 25; i++) cycle(1'b1, 32'h0, 32'h0, 8'h5A);
        // Reset priority over a live pc_in
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_BEEF, 32'h0, 8'h5A);
        // Sequential load after release
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd1, 32'd1, 8'h01);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd2, 32'd2, 8'h02);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd3, 32'd3, 8'h03);
        // Reset mid-run overrides pending load of 9, then 9 loads
        cycle(1'b1, 32'd9, 32'h0, 8'h5A);
        cycle(1'b0, 32'd9, 32'd9, 8'h09);
        // pc_in changes 5 -> 7 while clock is high
        mid(1'b0, 32'd5, 32'd5, 8'h05, 1'b0, 32'd7, 32'd7, 8'h07);
        // Extremes and odd patterns, no wrap
        cycle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF);
        cycle(1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00);
        cycle(1'b0, 32'h8000_0001, 32'h8000_0001, 8'h01);
        cycle(1'b0, 32'hA5A5_5A5B, 32'hA5A5_5A5B, 8'h5B);
        // Reset asserted between edges takes effect only at the next edge
        mid(1'b0, 32'h0000_1111, 32'h0000_1111, 8'h11, 1'b1, 32'h0000_2222, 32'h0, 8'h5A);
        // Reset released between edges: first non-reset edge loads pc_in
        mid(1'b1, 32'h0000_3333, 32'h0, 8'h5A, 1'b0, 32'h0000_1234, 32'h0000_1234, 8'h34);
        cycle(1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 8'h0D);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        @(negedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
